// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the EX-stage multiply/divide sequencer.
// M-extension opcode fields and sequencer state encoding.
package rv_pkg;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Shift-add multiply / restoring divide, one iteration per cycle.
module ex_muldiv_seq
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int W2 = 2 * XLEN;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;

    // Returns {rem, acc}. Divide keeps the dividend/quotient in acc low word.
    function automatic logic [XLEN+W2:0] muldiv_step(
        input logic            is_div,
        input logic [W2-1:0]   acc,
        input logic [XLEN:0]   rem,
        input logic [XLEN-1:0] b
    );
        logic [XLEN:0] sum;
        logic [XLEN:0] sh;
        logic [XLEN:0] diff;
        sum  = {1'b0, acc[W2-1:XLEN]} +
               (acc[0] ? {1'b0, b} : {(XLEN+1){1'b0}});
        sh   = {rem[XLEN-1:0], acc[XLEN-1]};
        diff = sh - {1'b0, b};
        if (!is_div)
            muldiv_step = {rem, sum, acc[XLEN-1:1]};
        else if (!diff[XLEN])
            muldiv_step = {diff, acc[W2-1:XLEN], acc[XLEN-2:0], 1'b1};
        else
            muldiv_step = {sh, acc[W2-1:XLEN], acc[XLEN-2:0], 1'b0};
    endfunction

    logic            sgn_a, sgn_b, sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf;
    logic [W2-1:0]   prod;
    logic [XLEN-1:0] quo, rmd;
    logic [XLEN+W2:0] step;

    always_comb begin
        sgn_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                (funct3 == F3_DIV)  || (funct3 == F3_REM);
        sgn_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) ||
                (funct3 == F3_REM);
        sa    = sgn_a & op_a[XLEN-1];
        sb    = sgn_b & op_b[XLEN-1];
        mag_a = sa ? -op_a : op_a;
        mag_b = sb ? -op_b : op_b;
        div_zero = funct3[2] && (op_b == '0);
        div_ovf  = funct3[2] && !funct3[0] &&
                   (op_a == SMIN) && (op_b == '1);
        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rmd  = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        step = muldiv_step(f3_q[2], acc_q, rem_q, b_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        done_d   = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (start && !flush) begin
                    f3_d  = funct3;
                    neg_d = (funct3 == F3_REM) ? sa : (sa ^ sb);
                    b_d   = mag_b;
                    acc_d = {{XLEN{1'b0}}, mag_a};
                    rem_d = '0;
                    cnt_d = '0;
                    if (div_zero) begin
                        result_d = funct3[1] ? op_a : '1;
                        done_d   = 1'b1;
                        state_d  = MD_DONE;
                    end else if (div_ovf) begin
                        result_d = funct3[1] ? '0 : SMIN;
                        done_d   = 1'b1;
                        state_d  = MD_DONE;
                    end else begin
                        state_d = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                if (flush) begin
                    state_d = MD_IDLE;
                end else begin
                    rem_d = step[XLEN+W2:W2];
                    acc_d = step[W2-1:0];
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(XLEN-1))
                        state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                if (flush) begin
                    state_d = MD_IDLE;
                end else begin
                    unique case (f3_q)
                        F3_MUL:                         result_d = prod[XLEN-1:0];
                        F3_MULH, F3_MULHSU, F3_MULHU:   result_d = prod[W2-1:XLEN];
                        F3_DIV, F3_DIVU:                result_d = quo;
                        default:                        result_d = rmd;
                    endcase
                    done_d  = 1'b1;
                    state_d = MD_DONE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign stall  = ((state_q == MD_IDLE) && start && !flush) ||
                    (state_q == MD_CALC) || (state_q == MD_FIX);
    assign done   = done_q;
    assign result = result_q;

endmodule
